// File: rtl/dct_stream_ctrl_pkg.sv
// dct_ctrl_pkg: shared types and helpers for the DCT stream controller.
//   dct_ctrl_state_t  sequencer state (IDLE, FEED)
//   DCT_BLOCK_PIXELS  pixels in one 8x8 DCT block
//   clog2()           counter/pointer width helper, usable in constant context
package dct_ctrl_pkg;

  localparam int DCT_BLOCK_PIXELS = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FEED = 1'b1
  } dct_ctrl_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dct_stream_ctrl_if.sv
// dct_stream_ctrl_if: bundles the three buses seen by the DCT stream controller.
//   s_axis_*  pixel-pair AXI-Stream input
//   dct_*     write/read side of the DCT core
//   m_axis_*  run-length AXI-Stream output
// Modports: master = controller view, slave = environment (source/DCT/sink) view.
interface dct_stream_ctrl_if #(
  parameter int DATA_WIDTH       = 8,
  parameter int RUNL_STAGE_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0]       s_axis_tdata;
  logic                          s_axis_tvalid;
  logic                          s_axis_tready;
  logic                          s_axis_tlast;
  logic [DATA_WIDTH-1:0]         dct_wdata0;
  logic [DATA_WIDTH-1:0]         dct_wdata1;
  logic                          dct_wen;
  logic                          dct_resetn;
  logic [RUNL_STAGE_WIDTH-1:0]   dct_rdata0;
  logic [RUNL_STAGE_WIDTH-1:0]   dct_rdata1;
  logic                          dct_rsync;
  logic [2*RUNL_STAGE_WIDTH-1:0] m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  dct_rdata0, dct_rdata1, dct_rsync, m_axis_tready,
    output s_axis_tready, dct_wdata0, dct_wdata1, dct_wen, dct_resetn,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output dct_rdata0, dct_rdata1, dct_rsync, m_axis_tready,
    input  s_axis_tready, dct_wdata0, dct_wdata1, dct_wen, dct_resetn,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/dct_stream_ctrl_fifo.sv
// dct_ctrl_fifo: synchronous first-word-fall-through FIFO.
//   i_clk/i_reset  clock, async active-high clear (pointers and count)
//   i_push/i_wdata write port; a push while full is dropped
//   i_pop          read acknowledge; ignored while empty
//   o_rdata        head entry, forced to 0 while empty
//   o_count        number of stored entries
module dct_ctrl_fifo
  import dct_ctrl_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [clog2(DEPTH):0]  o_count
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             empty, full, push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign push_ok = i_push & ~full;
  assign pop_ok  = i_pop & ~empty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= i_wdata;
  end

  assign o_rdata = empty ? '0 : mem_q[rd_q];
  assign o_count = cnt_q;

endmodule

// File: rtl/dct_stream_ctrl.sv
// dct_stream_ctrl: feeds pixel pairs to dct_main in whole blocks and drains
// run-length words through an output FIFO.
//   i_clk, i_reset  clock, async active-high reset
//   bus             dct_stream_ctrl_if.master (s_axis in, dct_* side, m_axis out)
//   o_busy          block in flight, results outstanding or FIFO non-empty
//   o_err           only with DCT_CTRL_CHECK_EN: sticky protocol error flag
// Optional feature macro: DCT_CTRL_CHECK_EN.
module dct_stream_ctrl
  import dct_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int RUNL_STAGE_WIDTH = 16,
  parameter int BLOCK_BEATS      = DCT_BLOCK_PIXELS / 2,
  parameter int FIFO_DEPTH       = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  dct_stream_ctrl_if.master bus,
`ifdef DCT_CTRL_CHECK_EN
  output logic              o_err,
`endif
  output logic              o_busy
);
  localparam int FW = 2*RUNL_STAGE_WIDTH + 1;
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;  // holds fifo_count + pending + BLOCK_BEATS
  localparam int BW = clog2(BLOCK_BEATS);
  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_FEED = 1'(FEED);

  logic [0:0]            state_q, state_d;
  logic [BW-1:0]         in_cnt_q, in_cnt_d, out_cnt_q;
  logic [CW-1:0]         pending_q, pending_d;
  logic [DATA_WIDTH-1:0] wdata0_q, wdata1_q;
  logic                  wen_q, resetn_q;
  logic [AW:0]           fifo_count;
  logic [FW-1:0]         fifo_rdata;
  logic                  hs, start, credit_ok, last_in, last_out, pop;

  assign hs        = bus.s_axis_tvalid & bus.s_axis_tready;
  assign last_in   = (in_cnt_q == BW'(BLOCK_BEATS-1));
  assign last_out  = (out_cnt_q == BW'(BLOCK_BEATS-1));
  // The DCT cannot stall, so a block starts only once every result it will
  // produce, plus everything still owed, is guaranteed a FIFO slot.
  assign credit_ok = (CW'(fifo_count) + pending_q + CW'(BLOCK_BEATS)) <= CW'(FIFO_DEPTH);
  // Hold off until the DCT has left reset.
  assign start     = (state_q == ST_IDLE) & resetn_q & credit_ok;
  assign pop       = bus.m_axis_tready & (fifo_count != '0);

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    if (start) begin
      state_d  = ST_FEED;
      in_cnt_d = '0;
    end else if (hs) begin
      in_cnt_d = in_cnt_q + 1'b1;
      if (last_in) state_d = ST_IDLE;
    end
  end

  always_comb begin
    pending_d = pending_q;
    case ({start, bus.dct_rsync})
      2'b11:   pending_d = pending_q + CW'(BLOCK_BEATS-1);
      2'b10:   pending_d = pending_q + CW'(BLOCK_BEATS);
      2'b01:   pending_d = (pending_q == '0) ? '0 : pending_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      pending_q <= '0;
      wen_q     <= 1'b0;
      wdata0_q  <= '0;
      wdata1_q  <= '0;
      resetn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      pending_q <= pending_d;
      resetn_q  <= 1'b1;
      wen_q     <= hs;
      if (hs) begin
        wdata0_q <= bus.s_axis_tdata[DATA_WIDTH-1:0];
        wdata1_q <= bus.s_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      if (bus.dct_rsync) out_cnt_q <= last_out ? '0 : out_cnt_q + 1'b1;
    end
  end

  dct_ctrl_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (bus.dct_rsync),
    .i_wdata ({bus.dct_rdata1, bus.dct_rdata0, last_out}),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_count (fifo_count)
  );

  assign bus.s_axis_tready = (state_q == ST_FEED);
  assign bus.dct_wen       = wen_q;
  assign bus.dct_wdata0    = wdata0_q;
  assign bus.dct_wdata1    = wdata1_q;
  assign bus.dct_resetn    = resetn_q;
  assign bus.m_axis_tvalid = (fifo_count != '0);
  assign bus.m_axis_tdata  = fifo_rdata[FW-1:1];
  assign bus.m_axis_tlast  = fifo_rdata[0];
  assign o_busy            = (state_q == ST_FEED) | (pending_q != '0) | (fifo_count != '0);

`ifdef DCT_CTRL_CHECK_EN
  logic err_q, fifo_full;
  assign fifo_full = (fifo_count == (AW+1)'(FIFO_DEPTH));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else if ((hs & (bus.s_axis_tlast != last_in)) |
                 (bus.dct_rsync & ((pending_q == '0) | fifo_full))) begin
      err_q <= 1'b1;
    end
  end
  assign o_err = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = bus.s_axis_tlast;
`endif

endmodule

// File: tb/tb_dct_stream_ctrl.sv
// Directed bench for dct_stream_ctrl: reset-release table plus hand-written
// sequences for output path, back-pressure credit, input gaps, mid-block reset
// and (with DCT_CTRL_CHECK_EN) the error flag.
module tb_dct_stream_ctrl;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int BB = 32;
  localparam int FD = 64;

  logic i_clk, i_reset, o_busy;
`ifdef DCT_CTRL_CHECK_EN
  logic o_err;
`endif

  dct_stream_ctrl_if #(.DATA_WIDTH(DW), .RUNL_STAGE_WIDTH(RW)) bus ();

  dct_stream_ctrl #(
    .DATA_WIDTH(DW), .RUNL_STAGE_WIDTH(RW), .BLOCK_BEATS(BB), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus),
`ifdef DCT_CTRL_CHECK_EN
    .o_err   (o_err),
`endif
    .o_busy  (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic        tvalid;
    logic [15:0] tdata;
    logic        exp_resetn;
    logic        exp_tready;
    logic        exp_wen;
    logic        exp_busy;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vt [36];
  int   checks;
  int   failures;

  function automatic logic [15:0] pix(input int k);
    return {8'(2*k + 65), 8'(2*k + 64)};
  endfunction

  function automatic logic [31:0] word(input int n);
    return {16'(n), 8'hA5, 8'(n)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.dct_rsync     = 1'b0;
    bus.dct_rdata0    = '0;
    bus.dct_rdata1    = '0;
    bus.m_axis_tready = 1'b0;
  endtask

  // Leaves the DUT two edges after reset release, i.e. first block in FEED.
  task automatic do_reset();
    drive_idle();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last, input string nm);
    int n;
    n = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = last;
    while (bus.s_axis_tready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({nm, ".tready"}, bus.s_axis_tready, 1'b1);
    tick();
    chk({nm, ".wen"}, bus.dct_wen, 1'b1);
    chk({nm, ".wdata"}, {bus.dct_wdata1, bus.dct_wdata0}, d);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic push_word(input int n);
    bus.dct_rsync  = 1'b1;
    bus.dct_rdata1 = word(n)[31:16];
    bus.dct_rdata0 = word(n)[15:0];
    tick();
    bus.dct_rsync  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive_idle();
    i_reset  = 1'b1;

    // Reset release with valid already high; row r is sampled r edges after release.
    for (int r = 0; r < 36; r++) begin
      vt[r].tvalid     = 1'b1;
      vt[r].tdata      = pix(r < 2 ? 0 : (r > 34 ? 32 : r - 2));
      vt[r].exp_resetn = (r >= 1);
      vt[r].exp_tready = (r >= 2 && r <= 33) || (r == 35);
      vt[r].exp_wen    = (r >= 3 && r <= 34);
      vt[r].exp_busy   = (r >= 2);
      vt[r].exp_wdata  = (r < 3) ? 16'h0 : pix(r > 34 ? 31 : r - 3);
    end

    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = pix(0);
    tick();
    tick();
    i_reset = 1'b0;
    chk("rst.m_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("rst.m_tlast",  bus.m_axis_tlast, 1'b0);
    chk("rst.m_tdata",  bus.m_axis_tdata, 32'h0);
    for (int r = 0; r < 36; r++) begin
      bus.s_axis_tvalid = vt[r].tvalid;
      bus.s_axis_tdata  = vt[r].tdata;
      chk($sformatf("v%0d.resetn", r), bus.dct_resetn, vt[r].exp_resetn);
      chk($sformatf("v%0d.tready", r), bus.s_axis_tready, vt[r].exp_tready);
      chk($sformatf("v%0d.wen", r), bus.dct_wen, vt[r].exp_wen);
      chk($sformatf("v%0d.wdata", r), {bus.dct_wdata1, bus.dct_wdata0}, vt[r].exp_wdata);
      chk($sformatf("v%0d.busy", r), o_busy, vt[r].exp_busy);
      tick();
    end

    // Output path: one block in, 32 results streamed straight out.
    do_reset();
    for (int k = 0; k < BB; k++) send_beat(pix(k), k == BB - 1, $sformatf("out.b%0d", k));
    chk("out.block_done", bus.s_axis_tready, 1'b0);
    bus.m_axis_tready = 1'b1;
    for (int n = 0; n < BB; n++) begin
      push_word(n);
      chk($sformatf("out.tvalid%0d", n), bus.m_axis_tvalid, 1'b1);
      chk($sformatf("out.tdata%0d", n), bus.m_axis_tdata, word(n));
      chk($sformatf("out.tlast%0d", n), bus.m_axis_tlast, n == BB - 1);
    end
    tick();
    chk("out.drained", bus.m_axis_tvalid, 1'b0);
    chk("out.drained_tdata", bus.m_axis_tdata, 32'h0);

    // Back-pressure: two blocks of credit, third waits for 32 pops.
    do_reset();
    for (int k = 0; k < BB; k++) send_beat(pix(k), k == BB - 1, $sformatf("bp.a%0d", k));
    for (int k = 0; k < BB; k++) send_beat(pix(k), k == BB - 1, $sformatf("bp.b%0d", k));
    for (int i = 0; i < 5; i++) begin
      chk("bp.no_third", bus.s_axis_tready, 1'b0);
      tick();
    end
    for (int n = 0; n < 2 * BB; n++) begin
      push_word(n);
      chk($sformatf("bp.fill%0d", n), bus.s_axis_tready, 1'b0);
    end
    push_word(16'h99);  // FIFO full: must be dropped
`ifdef DCT_CTRL_CHECK_EN
    chk("bp.err_overflow", o_err, 1'b1);
`endif
    chk("bp.busy", o_busy, 1'b1);
    for (int i = 0; i < BB; i++) begin
      chk($sformatf("bp.tvalid%0d", i), bus.m_axis_tvalid, 1'b1);
      chk($sformatf("bp.tdata%0d", i), bus.m_axis_tdata, word(i));
      chk($sformatf("bp.tlast%0d", i), bus.m_axis_tlast, (i % BB) == BB - 1);
      bus.m_axis_tready = 1'b1;
      tick();
      chk($sformatf("bp.hold%0d", i), bus.s_axis_tready, 1'b0);
    end
    bus.m_axis_tready = 1'b0;
    tick();
    chk("bp.third_start", bus.s_axis_tready, 1'b1);
    bus.m_axis_tready = 1'b1;
    for (int i = BB; i < 2 * BB; i++) begin
      chk($sformatf("bp.tdata%0d", i), bus.m_axis_tdata, word(i));
      chk($sformatf("bp.tlast%0d", i), bus.m_axis_tlast, (i % BB) == BB - 1);
      tick();
    end
    chk("bp.dropped_absent", bus.m_axis_tvalid, 1'b0);
    bus.m_axis_tready = 1'b0;

    // Input valid every other cycle.
    do_reset();
    for (int k = 0; k < BB; k++) begin
      send_beat(pix(k), k == BB - 1, $sformatf("gap.b%0d", k));
      chk($sformatf("gap.tready%0d", k), bus.s_axis_tready, k != BB - 1);
      tick();
      chk($sformatf("gap.wen%0d", k), bus.dct_wen, 1'b0);
    end

    // Reset pulsed at input beat 10 with results already queued.
    do_reset();
    for (int n = 0; n < 3; n++) push_word(n);
    for (int k = 0; k < 10; k++) send_beat(pix(k), 1'b0, $sformatf("mid.b%0d", k));
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = pix(10);
    #2;
    i_reset = 1'b1;
    #1;
    chk("mid.tready", bus.s_axis_tready, 1'b0);
    chk("mid.wen", bus.dct_wen, 1'b0);
    chk("mid.wdata", {bus.dct_wdata1, bus.dct_wdata0}, 16'h0);
    chk("mid.resetn", bus.dct_resetn, 1'b0);
    chk("mid.m_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("mid.m_tlast", bus.m_axis_tlast, 1'b0);
    chk("mid.m_tdata", bus.m_axis_tdata, 32'h0);
    chk("mid.busy", o_busy, 1'b0);
    tick();
    i_reset = 1'b0;
    bus.s_axis_tdata = pix(0);
    tick();
    chk("mid.resetn_rise", bus.dct_resetn, 1'b1);
    chk("mid.tready_low", bus.s_axis_tready, 1'b0);
    chk("mid.busy_idle", o_busy, 1'b0);
    for (int k = 0; k < BB; k++) send_beat(pix(k), k == BB - 1, $sformatf("mid.r%0d", k));
    chk("mid.block_done", bus.s_axis_tready, 1'b0);
    chk("mid.fifo_empty", bus.m_axis_tvalid, 1'b0);

`ifdef DCT_CTRL_CHECK_EN
    // Early tlast raises a sticky error.
    do_reset();
    chk("err.clear", o_err, 1'b0);
    for (int k = 0; k < 6; k++) begin
      send_beat(pix(k), k == 5, $sformatf("err.b%0d", k));
      chk($sformatf("err.flag%0d", k), o_err, k == 5);
    end
    tick();
    tick();
    chk("err.sticky", o_err, 1'b1);
    do_reset();
    chk("err.reset", o_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
